voq_egress_scheduler: RTL

// - Egress-side scheduler for one output port. Shares the port among N_IN virtual

---
 rtl/voq_egress_scheduler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/voq_egress_scheduler.sv
// rtl/voq_egress_scheduler.sv - round-robin egress scheduler over N_IN virtual output queues
module voq_egress_scheduler #(
    parameter int N_IN      = 4,
    parameter int ADDR_W    = 12,
    parameter int VOQ_DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_IN-1:0]          voq_write_i,
    input  logic [N_IN-1:0]          enable_i,
    output logic [N_IN-1:0]          read_req_o,
    input  logic [N_IN-1:0]          ptr_valid_i,
    input  logic [N_IN*ADDR_W-1:0]   ptr_i,
    input  logic [N_IN-1:0]          flood_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ADDR_W-1:0]        out_ptr_o,
    output logic                     out_flood_o,
    output logic [$clog2(N_IN)-1:0]  out_src_o,
    output logic                     overflow_o,
    output logic                     proto_err_o
);
    localparam int CNT_W = $clog2(VOQ_DEPTH) + 1;
    localparam int SRC_W = $clog2(N_IN);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt [N_IN];
    logic [SRC_W-1:0]   r_rr_ptr;
    logic [SRC_W-1:0]   r_gnt;
    logic [N_IN-1:0]    w_elig;
    logic               w_any;
    logic [SRC_W-1:0]   w_win;
    logic               w_issue;
    logic               w_capture;
    logic               w_stray;
    logic [N_IN-1:0]    w_gnt_mask;

    always_comb begin
        for (int k = 0; k < N_IN; k++) begin
            w_elig[k] = enable_i[k] && (r_cnt[k] != '0);
        end
    end

    // First eligible queue at or after rr_ptr, wrapping upward.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (!w_any && w_elig[(int'(r_rr_ptr) + i) % N_IN]) begin
                w_any = 1'b1;
                w_win = SRC_W'((int'(r_rr_ptr) + i) % N_IN);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ptr_valid_i[r_gnt]) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready_i) begin
                    w_issue     = w_any;
                    w_state_nxt = w_any ? S_WAIT : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A grant issued during reset would be discarded, so never emit it.
        if (rst) begin
            w_issue = 1'b0;
        end
    end

    assign read_req_o = w_issue ? (N_IN'(1) << w_win) : '0;
    assign w_gnt_mask = N_IN'(1) << r_gnt;
    assign w_capture  = (r_state == S_WAIT) && ptr_valid_i[r_gnt];
    assign w_stray    = (r_state == S_WAIT) ? |(ptr_valid_i & ~w_gnt_mask) : |ptr_valid_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_gnt       <= '0;
            out_valid_o <= 1'b0;
            out_ptr_o   <= '0;
            out_flood_o <= 1'b0;
            out_src_o   <= '0;
            overflow_o  <= 1'b0;
            proto_err_o <= 1'b0;
            for (int k = 0; k < N_IN; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_gnt    <= w_win;
                r_rr_ptr <= (w_win == SRC_W'(N_IN - 1)) ? '0 : w_win + 1'b1;
            end
            if (w_capture) begin
                out_valid_o <= 1'b1;
                out_ptr_o   <= ptr_i[int'(r_gnt)*ADDR_W +: ADDR_W];
                out_flood_o <= flood_i[r_gnt];
                out_src_o   <= r_gnt;
            end else if (r_state == S_HOLD && out_ready_i) begin
                out_valid_o <= 1'b0;
            end
            if (w_stray) begin
                proto_err_o <= 1'b1;
            end
            for (int k = 0; k < N_IN; k++) begin
                case ({voq_write_i[k], read_req_o[k]})
                    2'b10: begin
                        if (r_cnt[k] == CNT_W'(VOQ_DEPTH)) begin
                            overflow_o <= 1'b1;
                        end else begin
                            r_cnt[k] <= r_cnt[k] + 1'b1;
                        end
                    end
                    2'b01:   r_cnt[k] <= r_cnt[k] - 1'b1;
                    default: r_cnt[k] <= r_cnt[k];
                endcase
            end
        end
    end
endmodule
